// File: rtl/mux8_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux8_arb_pkg
// Shared constants, FSM state type and helpers for the 8-requester
// round-robin arbiter that drives the select lines of an 8:1 mux.
//   N_REQ   : number of requesters (one per mux data input)
//   SEL_W   : width of the encoded mux select
//   state_t : arbiter FSM states (IDLE, GRANT)
//   onehot8 : index -> one-hot 8-bit vector
// ---------------------------------------------------------------------------
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_pick.sv
// ---------------------------------------------------------------------------
// mux8_rr_pick
// Combinational round-robin search. Scans ptr+1, ptr+2, ... ptr+8 (mod 8)
// over req with masked positions removed and reports the first hit.
// Ports:
//   req   [7:0] in  : request vector
//   ptr   [2:0] in  : last owner; the search starts just after it
//   mask  [7:0] in  : positions excluded from the search
//   found       out : at least one unmasked request is present
//   idx   [2:0] out : winning index (0 when found=0)
// ---------------------------------------------------------------------------
module mux8_rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] pos;

    assign cand = req & ~mask;

    // Walk from the farthest position (ptr+8 == ptr) back to the nearest
    // (ptr+1) so the nearest hit is the last one written and therefore wins.
    // The 3-bit add wraps, which is exactly the mod-8 search order.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int d = N_REQ; d >= 1; d--) begin
            pos = ptr + SEL_W'(d);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing an 8:1 single-bit mux between 8 requesters.
// Grants one owner at a time, drives the mux select and a one-hot grant,
// and forces rotation after MAX_HOLD cycles when others are waiting.
// Optional feature macro: MUX8_ARB_LOCK_EN (adds 'lock', which suppresses
// the hold timeout while asserted during a grant).
// Ports:
//   clk            in  : rising-edge clock
//   rst_n          in  : asynchronous active-low reset
//   req      [7:0] in  : request vector, req[i] pairs with mux input i
//   lock           in  : (MUX8_ARB_LOCK_EN only) hold the grant past timeout
//   grant    [7:0] out : one-hot grant, zero when idle
//   sel      [2:0] out : owner index for mux Sel2..Sel0, 0 when idle
//   valid          out : a grant is active (also the FSM state: 1 = GRANT)
//   hold_cnt       out : cycles the current owner has held the grant
// Handshake: req[i] is a level request sampled at each rising edge; the
// arbiter answers one cycle later through registered grant/sel/valid. A
// requester keeps req high for as long as it wants the mux; dropping it
// releases ownership at the next edge.
// ---------------------------------------------------------------------------
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter  int MAX_HOLD = 16,
    localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
`ifdef MUX8_ARB_LOCK_EN
    input  logic              lock,
`endif
    output logic [N_REQ-1:0]  grant,
    output logic [SEL_W-1:0]  sel,
    output logic              valid,
    output logic [HOLD_W-1:0] hold_cnt
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N_REQ-1:0]  pick_mask;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              owner_req;
    logic              at_limit;
    logic              locked;

`ifdef MUX8_ARB_LOCK_EN
    assign locked = lock;
`else
    assign locked = 1'b0;
`endif

    // While granting, ptr_q always equals the owner, so one search from
    // ptr_q with the owner masked serves both release and timeout.
    assign pick_mask = (state_q == GRANT) ? onehot8(ptr_q) : '0;
    assign owner_req = req[ptr_q];
    assign at_limit  = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));

    mux8_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= SEL_W'(N_REQ - 1);
            sel_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // Release wins over a coincident timeout.
                    if (pick_found) begin
                        sel_d  = pick_idx;
                        ptr_d  = pick_idx;
                        hold_d = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        sel_d   = '0;
                        hold_d  = '0;
                    end
                end else if (at_limit && !locked) begin
                    // Hand over if anyone else waits; otherwise the lone
                    // owner keeps the grant and starts a fresh hold window.
                    if (pick_found) begin
                        sel_d = pick_idx;
                        ptr_d = pick_idx;
                    end
                    hold_d = HOLD_W'(1);
                end else if (!at_limit) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // Locked at the limit: counter saturates, owner stays.
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                hold_d  = '0;
            end
        endcase
        grant_d = (state_d == GRANT) ? onehot8(sel_d) : '0;
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign valid    = (state_q == GRANT);
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
// Bench for mux8_rr_arbiter built with MAX_HOLD=4: a cycle table from reset,
// hand-written reset/rotation sequences, then randomized requests checked
// against a behavioural owner/pointer model.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  localparam int MAXH = 4;
  localparam int HW   = 3;
  localparam int PW   = 8 + 3 + 1 + HW;

  logic          clk;
  logic          rst_n;
  logic [7:0]    req;
  logic          lock;
  logic [7:0]    grant;
  logic [2:0]    sel;
  logic          valid;
  logic [HW-1:0] hold_cnt;

  int n_vec;
  int n_fail;

  logic [PW-1:0] exp_q[$];

  mux8_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
`ifdef MUX8_ARB_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .sel      (sel),
    .valid    (valid),
    .hold_cnt (hold_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] pack(logic [7:0] g, logic [2:0] s, logic v, logic [HW-1:0] h);
    return {g, s, v, h};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] exp);
    logic [PW-1:0] act;
    act = {grant, sel, valid, hold_cnt};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%h sel=%0d valid=%0b hold=%0d, want grant=%h sel=%0d valid=%0b hold=%0d",
               name, act[PW-1 -: 8], act[HW+3 -: 3], act[HW], act[HW-1:0],
               exp[PW-1 -: 8], exp[HW+3 -: 3], exp[HW], exp[HW-1:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply req just after an edge; it is sampled at the next edge and the
  // outputs are looked at 1 time unit after that edge.
  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- reference model ----------------
  int m_own;
  int m_hold;
  int m_ptr;

  function automatic int rr_search(int p, logic [7:0] r);
    for (int d = 1; d <= 8; d++) begin
      if (r[(p + d) % 8]) return (p + d) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_hold = 0;
    m_ptr  = 7;
  endtask

  task automatic model_step(input logic [7:0] r);
    int w;
    logic [7:0] others;
    if (m_own < 0) begin
      w = rr_search(m_ptr, r);
      if (w >= 0) begin
        m_own = w; m_ptr = w; m_hold = 1;
      end
    end else if (!r[m_own]) begin
      w = rr_search(m_own, r);
      if (w >= 0) begin
        m_own = w; m_ptr = w; m_hold = 1;
      end else begin
        m_own = -1; m_hold = 0;
      end
    end else if (m_hold == MAXH) begin
      others = r;
      others[m_own] = 1'b0;
      w = rr_search(m_own, others);
      if (w >= 0) begin
        m_own = w; m_ptr = w;
      end
      m_hold = 1;
    end else begin
      m_hold = m_hold + 1;
    end
  endtask

  function automatic logic [PW-1:0] model_out();
    logic [7:0] g;
    if (m_own < 0) return '0;
    g = '0;
    g[m_own] = 1'b1;
    return pack(g, 3'(m_own), 1'b1, HW'(m_hold));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    r;
    logic [7:0]    g;
    logic [2:0]    s;
    logic          v;
    logic [HW-1:0] h;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int c;
    int o;
    logic [7:0] r;
    logic [7:0] g;
    n_vec  = 0;
    n_fail = 0;
    lock   = 1'b0;
    req    = 8'h00;
    rst_n  = 1'b0;

    // req, expected grant, sel, valid, hold (from idle, ptr=7)
    tbl[0]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
    tbl[1]  = '{8'h08, 8'h08, 3'd3, 1'b1, 3'd1};
    tbl[2]  = '{8'h08, 8'h08, 3'd3, 1'b1, 3'd2};
    tbl[3]  = '{8'h08, 8'h08, 3'd3, 1'b1, 3'd3};
    tbl[4]  = '{8'h28, 8'h08, 3'd3, 1'b1, 3'd4};
    tbl[5]  = '{8'h28, 8'h20, 3'd5, 1'b1, 3'd1};
    tbl[6]  = '{8'h21, 8'h20, 3'd5, 1'b1, 3'd2};
    tbl[7]  = '{8'h01, 8'h01, 3'd0, 1'b1, 3'd1};
    tbl[8]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
    tbl[9]  = '{8'h04, 8'h04, 3'd2, 1'b1, 3'd1};
    tbl[10] = '{8'h25, 8'h04, 3'd2, 1'b1, 3'd2};
    tbl[11] = '{8'h21, 8'h20, 3'd5, 1'b1, 3'd1};
    tbl[12] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd1};
    tbl[13] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd2};
    tbl[14] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd3};
    tbl[15] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd4};
    tbl[16] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd1};
    tbl[17] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd2};
    tbl[18] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd3};
    tbl[19] = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd4};
    tbl[20] = '{8'h02, 8'h02, 3'd1, 1'b1, 3'd1};
    tbl[21] = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};

    // ---- reset with all requests asserted ----
    req = 8'hFF;
    #2;
    check("async_reset_assert", pack(8'h00, 3'd0, 1'b0, 3'd0));
    @(posedge clk);
    #1;
    check("reset_held_req_ff", pack(8'h00, 3'd0, 1'b0, 3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_grant_after_reset", pack(8'h01, 3'd0, 1'b1, 3'd1));

    // ---- rotation: req=FF, each owner exactly MAXH cycles ----
    for (c = 1; c <= 8 * MAXH; c++) begin
      step(8'hFF);
      o = (c / MAXH) % 8;
      g = '0;
      g[o] = 1'b1;
      check($sformatf("rotation_c%0d", c), pack(g, 3'(o), 1'b1, HW'((c % MAXH) + 1)));
    end

    // ---- table from a fresh reset ----
    do_reset();
    check("reset_before_table", pack(8'h00, 3'd0, 1'b0, 3'd0));
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r);
      check($sformatf("table_%0d", i), pack(tbl[i].g, tbl[i].s, tbl[i].v, tbl[i].h));
    end

    // ---- single request drop ----
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(8'h08);
      check($sformatf("single_hold_%0d", i), pack(8'h08, 3'd3, 1'b1, HW'(((i - 1) % MAXH) + 1)));
    end
    step(8'h00);
    check("single_drop", pack(8'h00, 3'd0, 1'b0, 3'd0));

    // ---- async reset mid-grant, then re-arbitration from ptr=7 ----
    do_reset();
    step(8'h80);
    check("pre_reset_owner7", pack(8'h80, 3'd7, 1'b1, 3'd1));
    step(8'h08);
    check("pre_reset_owner3", pack(8'h08, 3'd3, 1'b1, 3'd1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_grant", pack(8'h00, 3'd0, 1'b0, 3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h88;
    @(posedge clk);
    #1;
    check("rearb_after_reset", pack(8'h08, 3'd3, 1'b1, 3'd1));

    // ---- randomized against the model ----
    do_reset();
    model_reset();
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       r = 8'($urandom_range(0, 255));
        1:       r = 8'h00;
        2:       r[$urandom_range(0, 7)] = 1'b1;
        3:       r[$urandom_range(0, 7)] = 1'b0;
        default: r = r;
      endcase
      model_step(r);
      exp_q.push_back(model_out());
      step(r);
      check($sformatf("random_%0d", i), exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
